ram_stream_reader: RTL and testbench

//  Read-side sequencer for the behavioural dual-port RAM (r_addr/r_en/r_data, 1-cycle read latency).
//  On start it issues sequential reads from base_addr for len words and streams them out on a

---
 rtl/ram_if_pkg.sv | 23 ++
 rtl/ram_rd_buf.sv | 55 +++++
 rtl/ram_stream_reader.sv | 115 +++++++++++
 tb/tb_ram_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_if_pkg.sv
// =============================================================================
// Module      : ram_if_pkg
// Description : Shared RAM interface constants and read-sequencer state type.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package ram_if_pkg;

    localparam int RAM_AW    = 8;
    localparam int RAM_DW    = 32;
    localparam int RD_LAT    = 1;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_rd_buf.sv
// =============================================================================
// Module      : ram_rd_buf
// Description : Two-entry synchronous FIFO absorbing RAM read data under backpressure.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module ram_rd_buf
    import ram_if_pkg::*;
#(
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// =============================================================================
// Module      : ram_stream_reader
// Description : Issues sequential RAM reads and streams the words out on valid/ready.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module ram_stream_reader
    import ram_if_pkg::*;
#(
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] r_addr,
    output logic          r_en,
    input  logic [DW-1:0] r_data,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready
);

    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [2:0]    OCC_LIMIT = 3'(DEPTH);

    rd_state_t     r_state;
    rd_state_t     w_state_next;
    logic [AW-1:0] r_rd_addr;
    logic [AW:0]   r_rem_issue;
    logic [AW:0]   r_rem_acc;
    logic          r_inflight;
    logic          w_issue;
    logic          w_pop;
    logic [1:0]    w_count;
    logic [2:0]    w_occ;

    ram_rd_buf #(
        .DW (DW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .din   (r_data),
        .pop   (w_pop),
        .dout  (m_data),
        .count (w_count)
    );

    assign m_valid = (w_count != 2'd0);
    assign w_pop   = m_valid && m_ready;
    // Projected occupancy once the read already in flight lands and this cycle's pop leaves.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = (r_rem_issue != '0) && (w_occ < OCC_LIMIT);
                if (w_pop && (r_rem_acc == CNT_ONE)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_rem_issue <= '0;
            r_rem_acc   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if ((r_state == ST_IDLE) && start) begin
                r_rd_addr   <= base_addr;
                r_rem_issue <= len;
                r_rem_acc   <= len;
            end else begin
                if (w_issue) begin
                    r_rd_addr   <= r_rd_addr + ADDR_ONE;
                    r_rem_issue <= r_rem_issue - CNT_ONE;
                end
                if (w_pop && (r_state == ST_RUN)) begin
                    r_rem_acc <= r_rem_acc - CNT_ONE;
                end
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign r_en   = w_issue;
    assign r_addr = r_rd_addr;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// =============================================================================
// Module      : tb_ram_stream_reader
// Description : Self-checking bench: RAM model, cycle model of the issue rule, word scoreboard.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_ram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic [7:0]  r_addr;
    logic        r_en;
    logic [31:0] r_data;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;

    ram_stream_reader #(
        .AW    (8),
        .DW    (32),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .r_addr    (r_addr),
        .r_en      (r_en),
        .r_data    (r_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, mem[i] = i, one-cycle read latency
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        r_data = 32'd0;
    end
    always @(posedge clk) if (r_en) r_data <= mem[r_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int ecnt = 0;
    always @(posedge clk) ecnt++;

    // m_ready pattern generator: 0 = always 1, 1 = 1,0,0,1 repeating, 2 = random
    int rmode = 0;
    int rphase = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    m_ready = (rphase == 0) || (rphase == 3);
                    rphase  = (rphase + 1) % 4;
                end
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    logic [31:0] exp_q [$];
    logic [7:0]  addr_q [$];
    int          issue_left = 0;
    int          mdl_cnt = 0;
    int          mdl_inf = 0;
    int          mdl_occ;
    logic        mon_pop;
    logic        exp_ren;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    int          first_valid_edge;
    int          last_hs_edge;
    int          done_edge;
    int          hs_cnt;
    int          done_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_cnt    = 0;
            mdl_inf    = 0;
            prev_stall = 1'b0;
        end else begin
            mon_pop = m_valid && m_ready;
            mdl_occ = mdl_cnt + mdl_inf - (mon_pop ? 1 : 0);
            exp_ren = busy && !done && (issue_left != 0) && (mdl_occ < 2);
            chk("m_valid", longint'(m_valid), longint'(mdl_cnt != 0));
            chk("r_en", longint'(r_en), longint'(exp_ren));
            if (r_en) begin
                if (addr_q.size() == 0) chk("extra_issue", 1, 0);
                else chk("r_addr", longint'(r_addr), longint'(addr_q.pop_front()));
            end
            if (prev_stall) chk("stall_hold", longint'({m_valid, m_data}), longint'({1'b1, prev_data}));
            if (m_valid && (first_valid_edge < 0)) first_valid_edge = ecnt;
            if (mon_pop) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("m_data", longint'(m_data), longint'(exp_q.pop_front()));
                hs_cnt++;
                last_hs_edge = ecnt;
            end
            if (done) begin
                done_cnt++;
                done_edge = ecnt;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            mdl_cnt    = mdl_occ;
            mdl_inf    = r_en ? 1 : 0;
            if (r_en && (issue_left > 0)) issue_left--;
        end
    end

    task automatic clear_stats();
        first_valid_edge = -1;
        last_hs_edge     = -1;
        done_edge        = -1;
        hs_cnt           = 0;
        done_cnt         = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},    longint'(busy),    0);
        chk({tag, "_done"},    longint'(done),    0);
        chk({tag, "_r_en"},    longint'(r_en),    0);
        chk({tag, "_r_addr"},  longint'(r_addr),  0);
        chk({tag, "_m_valid"}, longint'(m_valid), 0);
        chk({tag, "_m_data"},  longint'(m_data),  0);
    endtask

    // Called at posedge+1 with the DUT idle; inj>0 pulses a second start that cycle into the run
    task automatic run_xfer(input logic [7:0] b, input logic [8:0] n, input int mode,
                            input int exp_lat, input int inj);
        logic [7:0] a;
        int         start_edge;
        bit         seen;
        rmode = mode;
        clear_stats();
        a = b;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({24'd0, a});
            addr_q.push_back(a);
            a = a + 8'd1;
        end
        issue_left = int'(n);
        start      = 1'b1;
        base_addr  = b;
        len        = n;
        start_edge = ecnt + 1;
        seen       = 1'b0;
        for (int k = 0; k < int'(n) * 6 + 20; k++) begin
            @(posedge clk);
            #1;
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            if ((inj != 0) && (k == inj)) begin
                start     = 1'b1;
                base_addr = 8'h80;
                len       = 9'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", longint'(seen), 1);
        chk("busy_after_done", longint'(busy), 0);
        chk("words_accepted", hs_cnt, longint'(n));
        if (n != 0) begin
            chk("first_valid_latency", first_valid_edge - start_edge, exp_lat);
            chk("done_after_last_word", done_edge, last_hs_edge + 1);
            if (mode == 0) chk("back_to_back", last_hs_edge - first_valid_edge, longint'(n) - 1);
        end else begin
            chk("len0_done_edge", done_edge, start_edge);
            chk("len0_no_valid", first_valid_edge, -1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulse_count", done_cnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("addr_queue_empty", addr_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         rmode;
        int         inj;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit hit;
        vecs[0] = '{8'h10, 9'd4,   0, 0, 2};
        vecs[1] = '{8'hFE, 9'd4,   0, 0, 2};
        vecs[2] = '{8'h20, 9'd8,   1, 0, 2};
        vecs[3] = '{8'h33, 9'd0,   0, 0, 2};
        vecs[4] = '{8'h50, 9'd6,   1, 3, 2};
        vecs[5] = '{8'h30, 9'd12,  2, 0, 2};
        vecs[6] = '{8'hF0, 9'd1,   0, 0, 2};
        vecs[7] = '{8'h80, 9'd256, 2, 0, 2};

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = 8'd0;
        len       = 9'd0;
        clear_stats();
        #3;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].rmode, vecs[v].exp_lat, vecs[v].inj);
        end

        // Reset asserted after three of eight words have been handed over
        rmode = 0;
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(i));
            addr_q.push_back(8'(i));
        end
        issue_left = 8;
        start      = 1'b1;
        base_addr  = 8'h00;
        len        = 9'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hs_cnt >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("three_words_before_reset", longint'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        addr_q.delete();
        issue_left = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("held_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(8'h40, 9'd2, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
